// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port controller.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DEST_MDR = 1'b0;
  localparam logic DEST_IR  = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating wait counter for the REQ phase; expired flags the last allowed cycle.
module bus_timeout_cnt #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted during the TIMEOUT-th REQ cycle so the abort lands after exactly TIMEOUT cycles.
  assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-side stage: runs one request/ready bus transaction per access and holds IR and MDR.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iord,
  input  logic              memwrite,
  input  logic              irwrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  logic   dest;
  logic   wr, rd, acc;
  logic   to_en, to_clr, expired;

  // A write wins over a simultaneous fetch request.
  assign wr  = memwrite;
  assign rd  = ~memwrite & (irwrite | iord);
  assign acc = wr | rd;

  assign stall  = (state == IDLE && acc) || (state == REQ);
  assign to_en  = (state == REQ);
  assign to_clr = to_en & (mem_ready | expired);

  bus_timeout_cnt #(
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) u_to (
    .clk    (clk),
    .rst    (rst),
    .en     (to_en),
    .clr    (to_clr),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dest      <= DEST_MDR;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instr     <= '0;
      mdr       <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            mem_addr  <= iord ? aluout : pc;
            mem_wdata <= wdata;
            mem_we    <= wr;
            dest      <= irwrite ? DEST_IR : DEST_MDR;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              if (dest == DEST_IR) instr <= mem_rdata;
              else                 mdr   <= mem_rdata;
            end
            state <= DONE;
          end else if (expired) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench: transaction-level model of the memory port plus directed and random accesses.
module tb_mem_port_ctrl;

  localparam int TO = 4;

  logic        clk, rst;
  logic        iord, memwrite, irwrite;
  logic [31:0] pc, aluout, wdata;
  logic        stall, bus_err, mem_req, mem_we, mem_ready;
  logic [31:0] instr, mdr, mem_addr, mem_wdata, mem_rdata;

  mem_port_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TO_W(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pc(pc), .aluout(aluout), .wdata(wdata), .stall(stall), .instr(instr),
    .mdr(mdr), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int stall_cnt = 0;
  int req_cnt = 0;

  // expected outputs for the current cycle
  logic        e_stall, e_req, e_we, e_err;
  logic [31:0] e_addr, e_wdata, e_instr, e_mdr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",     32'(stall),   32'(e_stall));
      check("mem_req",   32'(mem_req), 32'(e_req));
      check("mem_we",    32'(mem_we),  32'(e_we));
      check("bus_err",   32'(bus_err), 32'(e_err));
      check("mem_addr",  mem_addr,  e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("instr",     instr,     e_instr);
      check("mdr",       mdr,       e_mdr);
      if (stall === 1'b1) stall_cnt++;
      if (mem_req === 1'b1) req_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memwrite = 1'b0; irwrite = 1'b0; iord = 1'b0;
    pc = $urandom; aluout = $urandom; wdata = $urandom;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    e_stall = 1'b0; e_req = 1'b0;
  endtask

  task automatic junk_inputs();
    memwrite = 1'($urandom); irwrite = 1'($urandom); iord = 1'($urandom);
    pc = $urandom; aluout = $urandom; wdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      step();
    end
    idle_inputs();
  endtask

  // One access: issue cycle, n REQ cycles (ready on the last unless it times out), one DONE cycle.
  task automatic access(input logic mw, input logic ir, input logic io,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] w,
                        input int delay, input logic [31:0] rdat);
    bit to;
    int n;
    to = (delay + 1 > TO);
    n  = to ? TO : delay + 1;
    memwrite = mw; irwrite = ir; iord = io; pc = p; aluout = a; wdata = w;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    e_stall = 1'b1; e_req = 1'b0;
    stall_cnt = 0; req_cnt = 0;
    step();
    e_addr = io ? a : p; e_wdata = w; e_we = mw;
    for (int k = 1; k <= n; k++) begin
      junk_inputs();
      mem_ready = (!to && k == n);
      mem_rdata = (k == n) ? rdat : $urandom;
      e_stall = 1'b1; e_req = 1'b1;
      step();
    end
    if (to) e_err = 1'b1;
    else begin
      e_we = 1'b0;
      if (!mw) begin
        if (ir) e_instr = rdat;
        else    e_mdr   = rdat;
      end
    end
    junk_inputs();
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    e_stall = 1'b0; e_req = 1'b0;
    step();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_stall",   32'(stall),   32'h0);
    check("rst_instr",   instr,        32'h0);
    check("rst_addr",    mem_addr,     32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();
    e_we = 0; e_err = 0; e_addr = 0; e_wdata = 0; e_instr = 0; e_mdr = 0;
    idle_inputs();
    chk_en = 1'b1;
    idle(2);

    // fetch with two wait cycles
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 2, 32'h8C220004);
    check("fetch_instr",  instr,     32'h8C220004);
    check("fetch_model",  e_instr,   32'h8C220004);
    check("fetch_mdr",    mdr,       32'h0);
    check("fetch_stall",  stall_cnt, 4);
    // load back to back, ready in first REQ cycle
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h104, 32'h0, 0, 32'hDEADBEEF);
    check("load_mdr",     mdr,       32'hDEADBEEF);
    check("load_instr",   instr,     32'h8C220004);
    check("load_stall",   stall_cnt, 2);
    // store
    access(1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h12345678, 1, 32'hCAFEF00D);
    check("store_wdata",  mem_wdata, 32'h12345678);
    check("store_mdr",    mdr,       32'hDEADBEEF);
    check("store_instr",  instr,     32'h8C220004);
    // write and fetch together: write wins
    access(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'hA5A5A5A5, 0, 32'h11111111);
    check("conf_instr",   instr,     32'h8C220004);
    check("conf_addr",    mem_addr,  32'h300);
    idle(1);
    // timeout read
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h400, 32'h0, 10, 32'h22222222);
    check("to_err",       32'(bus_err), 32'h1);
    check("to_req_cnt",   req_cnt,   4);
    check("to_stall",     stall_cnt, 5);
    check("to_mdr",       mdr,       32'hDEADBEEF);
    idle(3);
    check("to_sticky",    32'(bus_err), 32'h1);

    // reset in the middle of a REQ wait
    irwrite = 1'b1; pc = 32'h80;
    e_stall = 1'b1; e_req = 1'b0;
    step();
    e_addr = 32'h80; e_wdata = wdata; e_we = 1'b0;
    mem_ready = 1'b0; e_req = 1'b1;
    step();
    step();
    chk_en = 1'b0;
    idle_inputs();
    mem_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req",   32'(mem_req), 32'h0);
    check("mid_rst_stall", 32'(stall),   32'h0);
    check("mid_rst_err",   32'(bus_err), 32'h0);
    check("mid_rst_out",   instr | mdr | mem_addr | mem_wdata | 32'(mem_we), 32'h0);
    step();
    #2 rst = 1'b1;
    e_we = 0; e_err = 0; e_addr = 0; e_wdata = 0; e_instr = 0; e_mdr = 0;
    mem_ready = 1'b1; mem_rdata = 32'hBADBAD00;
    chk_en = 1'b1;
    step();
    idle(2);
    check("late_ready", instr | mdr, 32'h0);

    // randomized accesses
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: access(1'b0, 1'b1, 1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom);
        1: access(1'b0, 1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom);
        2: access(1'b1, 1'b0, 1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom);
        default: access(1'b1, 1'b1, 1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom);
      endcase
      idle($urandom_range(0, 2));
    end

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
